note_sequencer: RTL and testbench

Melody controller that sequences one audio_sample channel. It holds a small programmable note table (frequency word plus duration in beats) and, after start, retunes the channel once per note. Each note is retuned with a one-cycle ch_en_o pulse and a new ch_freq_o, then held for its duration. It sits between the CPU/config logic and the audio_sample datapath, and replaces hand-sequenced en/freq stimulus.

---
 rtl/note_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody controller: sequences one audio_sample channel from a small
// programmable note table (frequency word + duration in beats). Each note is
// announced with a one-cycle ch_en_o strobe carrying the new frequency word.
module note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int DUR_W    = 4,
  parameter int BEAT_DIV = 3125000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [15:0]       wr_freq_i,
  input  logic [DUR_W-1:0]  wr_dur_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              loop_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              ch_en_o,
  output logic [15:0]       ch_freq_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] note_idx_o,
  output logic              done_o
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(BEAT_DIV);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEAT_DIV - 1);
  // The LOAD cycle is part of each note's budget, so HOLD leaves one
  // cycle early on the last beat.
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(BEAT_DIV - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [15:0]      freq_tab_q [DEPTH];
  logic [DUR_W-1:0] dur_tab_q  [DEPTH];

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              loop_q, loop_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DUR_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ch_en_q, ch_en_d;
  logic [15:0]       ch_freq_q, ch_freq_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_freq;
  logic [DUR_W-1:0]  rd_dur;
  logic [LEN_W-1:0]  idx_next;
  logic              go_idle;

  assign rd_addr  = idx_q[ADDR_W-1:0];
  assign rd_freq  = freq_tab_q[rd_addr];
  assign rd_dur   = dur_tab_q[rd_addr];
  assign idx_next = idx_q + LEN_W'(1);

  // Note table: cleared on reset, written from the config port. A LOAD in the
  // same cycle as a write to that entry still sees the old contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        freq_tab_q[i] <= '0;
        dur_tab_q[i]  <= '0;
      end
    end else if (wr_en_i && ({1'b0, wr_addr_i} < LEN_MAX)) begin
      freq_tab_q[wr_addr_i] <= wr_freq_i;
      dur_tab_q[wr_addr_i]  <= wr_dur_i;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      loop_q     <= 1'b0;
      idx_q      <= '0;
      beats_q    <= '0;
      cnt_q      <= '0;
      ch_en_q    <= 1'b0;
      ch_freq_q  <= '0;
      busy_q     <= 1'b0;
      note_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      idx_q      <= idx_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      ch_en_q    <= ch_en_d;
      ch_freq_q  <= ch_freq_d;
      busy_q     <= busy_d;
      note_idx_q <= note_idx_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: start/load/hold sequencing, end-of-sequence and abort
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    loop_d     = loop_q;
    idx_d      = idx_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    ch_en_d    = 1'b0;
    ch_freq_d  = ch_freq_q;
    busy_d     = busy_q;
    note_idx_d = note_idx_q;
    done_d     = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
            loop_d  = loop_i;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (stop_i) begin
          go_idle = 1'b1;
        end else if ((idx_q >= len_q) || (rd_dur == '0)) begin
          // Ran past the last entry or hit an end marker
          go_idle = 1'b1;
          done_d  = 1'b1;
        end else begin
          ch_en_d    = 1'b1;
          ch_freq_d  = rd_freq;
          note_idx_d = rd_addr;
          beats_d    = rd_dur;
          cnt_d      = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stop_i) begin
          go_idle = 1'b1;
        end else if ((beats_q == DUR_W'(1)) && (cnt_q == CNT_FINAL)) begin
          // idx == len afterwards means the next LOAD ends the sequence
          state_d = S_LOAD;
          idx_d   = ((idx_next == len_q) && loop_q) ? '0 : idx_next;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          beats_d = beats_q - DUR_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving playback always silences the channel with one load strobe
    if (go_idle) begin
      state_d   = S_IDLE;
      ch_en_d   = 1'b1;
      ch_freq_d = '0;
      busy_d    = 1'b0;
    end
  end

  assign ch_en_o    = ch_en_q;
  assign ch_freq_o  = ch_freq_q;
  assign busy_o     = busy_q;
  assign note_idx_o = note_idx_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: table-driven scenarios, a reset corner case and
// randomized traffic, all checked against a note-schedule reference model.
module tb_note_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int BD    = 4;
  localparam int NC    = 160;
  localparam int NV    = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_addr_i = '0;
  logic [15:0] wr_freq_i = '0;
  logic [3:0]  wr_dur_i = '0;
  logic [4:0]  len_i = '0;
  logic        loop_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        ch_en_o;
  logic [15:0] ch_freq_o;
  logic        busy_o;
  logic [3:0]  note_idx_o;
  logic        done_o;

  note_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DUR_W(DW), .BEAT_DIV(BD)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_freq_i(wr_freq_i), .wr_dur_i(wr_dur_i), .len_i(len_i), .loop_i(loop_i),
    .start_i(start_i), .stop_i(stop_i), .ch_en_o(ch_en_o), .ch_freq_o(ch_freq_o),
    .busy_o(busy_o), .note_idx_o(note_idx_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-cycle stimulus for one run
  logic        st_a [NC];
  logic        sp_a [NC];
  logic        we_a [NC];
  logic        lp_a [NC];
  logic [3:0]  wa_a [NC];
  logic [3:0]  wd_a [NC];
  logic [15:0] wf_a [NC];
  logic [4:0]  ln_a [NC];

  // Inputs that were applied during the previous cycle
  logic        p_start, p_stop, p_we, p_loop;
  logic [3:0]  p_wa, p_wd;
  logic [15:0] p_wf;
  logic [4:0]  p_len;

  // Reference model: table shadow plus the time of the next note event
  int m_f [DEPTH];
  int m_d [DEPTH];
  bit m_active, m_loop, e_en, e_done;
  int m_now, m_t, m_i, m_len, m_freq, m_nidx;

  int act_t[$], act_f[$], act_d[$], et[$], ef[$];

  typedef struct packed {
    int len; int loop; int stop_at; int xs; int wr_at;
    int wa; int wf; int wd; int done_at; int ncyc;
  } vec_t;

  typedef struct packed { int v; int t; int f; } pexp_t;

  vec_t  vt [NV];
  pexp_t pe [$];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, c, act, exp);
    end
  endtask

  function automatic vec_t mkv(int len, int loop, int stop_at, int xs, int wr_at,
                               int wa, int wf, int wd, int done_at, int ncyc);
    vec_t v;
    v.len = len; v.loop = loop; v.stop_at = stop_at; v.xs = xs; v.wr_at = wr_at;
    v.wa = wa; v.wf = wf; v.wd = wd; v.done_at = done_at; v.ncyc = ncyc;
    return v;
  endfunction

  task automatic addp(input int v, input int t, input int f);
    pexp_t p;
    p.v = v; p.t = t; p.f = f;
    pe.push_back(p);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_f[i] = 0;
      m_d[i] = 0;
    end
    m_active = 0; m_loop = 0; m_t = 0; m_i = 0; m_len = 0; m_freq = 0; m_nidx = 0;
    p_start = 0; p_stop = 0; p_we = 0; p_loop = 0;
    p_wa = '0; p_wd = '0; p_wf = '0; p_len = '0;
  endtask

  // Expected outputs of the cycle now starting, from last cycle's inputs.
  // Note k sounds at an event time; the next note follows dur*BD cycles later.
  task automatic model_step();
    m_now++;
    e_en = 0;
    e_done = 0;
    if (m_active && p_stop) begin
      e_en = 1; m_freq = 0; m_active = 0;
    end else if (m_active && m_now == m_t) begin
      if (m_i >= m_len) begin
        e_en = 1; e_done = 1; m_freq = 0; m_active = 0;
      end else if (m_d[m_i] == 0) begin
        e_en = 1; e_done = 1; m_freq = 0; m_active = 0;
      end else begin
        e_en = 1;
        m_freq = m_f[m_i];
        m_nidx = m_i;
        m_t = m_now + m_d[m_i] * BD;
        m_i++;
        if (m_i == m_len && m_loop) m_i = 0;
      end
    end else if (!m_active && p_start) begin
      if (p_len == 0) e_done = 1;
      else begin
        m_active = 1;
        m_i = 0;
        m_t = m_now + 1;
        m_len = (int'(p_len) > DEPTH) ? DEPTH : int'(p_len);
        m_loop = p_loop;
      end
    end
    // Writes land after any read made in the same cycle
    if (p_we) begin
      m_f[p_wa] = int'(p_wf);
      m_d[p_wa] = int'(p_wd);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      st_a[c] = 0; sp_a[c] = 0; we_a[c] = 0; lp_a[c] = 0;
      wa_a[c] = '0; wd_a[c] = '0; wf_a[c] = '0; ln_a[c] = '0;
    end
    act_t.delete(); act_f.delete(); act_d.delete();
  endtask

  task automatic run(input string nm, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      model_step();
      chk(nm, c, {9'd0, ch_en_o, ch_freq_o, busy_o, done_o, note_idx_o},
                 {9'd0, e_en, m_freq[15:0], m_active, e_done, m_nidx[3:0]});
      if (ch_en_o === 1'b1) begin
        act_t.push_back(c);
        act_f.push_back(int'(ch_freq_o));
      end
      if (done_o === 1'b1) act_d.push_back(c);
      start_i = st_a[c]; stop_i = sp_a[c]; wr_en_i = we_a[c]; wr_addr_i = wa_a[c];
      wr_freq_i = wf_a[c]; wr_dur_i = wd_a[c]; len_i = ln_a[c]; loop_i = lp_a[c];
      p_start = st_a[c]; p_stop = sp_a[c]; p_we = we_a[c]; p_wa = wa_a[c];
      p_wf = wf_a[c]; p_wd = wd_a[c]; p_len = ln_a[c]; p_loop = lp_a[c];
    end
  endtask

  initial begin
    string nm;
    model_reset();
    m_now = 0;

    // Scenario table: start always in cycle 10; e0=(1849,2) e1=(2197,1) e2=(2468,3)
    vt[0] = mkv(3, 0, -1, -1, -1, 0, 0, 0, 36, 60);
    addp(0, 12, 1849); addp(0, 20, 2197); addp(0, 24, 2468); addp(0, 36, 0);
    vt[1] = mkv(3, 1, 40, -1, -1, 0, 0, 0, -1, 60);
    addp(1, 12, 1849); addp(1, 20, 2197); addp(1, 24, 2468); addp(1, 36, 1849); addp(1, 41, 0);
    vt[2] = mkv(0, 0, -1, -1, -1, 0, 0, 0, 11, 30);
    vt[3] = mkv(2, 0, -1, -1, -1, 0, 0, 0, 24, 40);
    addp(3, 12, 1849); addp(3, 20, 2197); addp(3, 24, 0);
    vt[4] = mkv(3, 0, -1, 15, -1, 0, 0, 0, 36, 60);
    addp(4, 12, 1849); addp(4, 20, 2197); addp(4, 24, 2468); addp(4, 36, 0);
    vt[5] = mkv(3, 1, 50, -1, 19, 1, 2615, 1, -1, 60);
    addp(5, 12, 1849); addp(5, 20, 2197); addp(5, 24, 2468); addp(5, 36, 1849);
    addp(5, 44, 2615); addp(5, 48, 2468); addp(5, 51, 0);
    vt[6] = mkv(3, 0, -1, -1, 2, 1, 2197, 0, 20, 40);
    addp(6, 12, 1849); addp(6, 20, 0);
    // Full table of 1-beat notes, len above DEPTH: plays exactly DEPTH notes
    vt[7] = mkv(20, 0, -1, -1, -1, 0, 0, 0, 76, 90);
    for (int i = 0; i < DEPTH; i++) addp(7, 12 + 4 * i, 1000 + i);
    addp(7, 76, 0);

    // Reset values, asynchronously applied
    #1;
    chk("reset", 0, {9'd0, ch_en_o, ch_freq_o, busy_o, done_o, note_idx_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #4 rst_i = 1'b0;

    clear_stim();
    we_a[0] = 1; wa_a[0] = 4'd0; wf_a[0] = 16'd1849; wd_a[0] = 4'd2;
    we_a[1] = 1; wa_a[1] = 4'd1; wf_a[1] = 16'd2197; wd_a[1] = 4'd1;
    we_a[2] = 1; wa_a[2] = 4'd2; wf_a[2] = 16'd2468; wd_a[2] = 4'd3;
    run("setup", 6);

    for (int k = 0; k < NV; k++) begin
      clear_stim();
      nm = $sformatf("vec%0d", k);
      if (k == 7) begin
        for (int i = 0; i < DEPTH; i++) begin
          we_a[i] = 1; wa_a[i] = 4'(i); wf_a[i] = 16'(1000 + i); wd_a[i] = 4'd1;
        end
      end
      for (int c = 0; c < NC; c++) begin
        ln_a[c] = 5'(vt[k].len);
        lp_a[c] = (vt[k].loop != 0);
      end
      st_a[10] = 1;
      if (vt[k].stop_at >= 0) sp_a[vt[k].stop_at] = 1;
      if (vt[k].xs >= 0) st_a[vt[k].xs] = 1;
      if (vt[k].wr_at >= 0) begin
        we_a[vt[k].wr_at] = 1;
        wa_a[vt[k].wr_at] = 4'(vt[k].wa);
        wf_a[vt[k].wr_at] = 16'(vt[k].wf);
        wd_a[vt[k].wr_at] = 4'(vt[k].wd);
      end
      run(nm, vt[k].ncyc);
      et.delete();
      ef.delete();
      foreach (pe[j]) if (pe[j].v == k) begin
        et.push_back(pe[j].t);
        ef.push_back(pe[j].f);
      end
      chk({nm, ":npulse"}, 0, act_t.size(), et.size());
      for (int j = 0; j < et.size(); j++) begin
        if (j < act_t.size()) begin
          chk({nm, ":pulse_cyc"}, j, act_t[j], et[j]);
          chk({nm, ":pulse_freq"}, j, act_f[j], ef[j]);
        end
      end
      if (vt[k].done_at < 0) chk({nm, ":ndone"}, 0, act_d.size(), 0);
      else begin
        chk({nm, ":ndone"}, 0, act_d.size(), 1);
        if (act_d.size() > 0) chk({nm, ":done_cyc"}, 0, act_d[0], vt[k].done_at);
      end
    end

    // Reset in the middle of a held note, then replay an emptied table
    clear_stim();
    st_a[10] = 1;
    for (int c = 0; c < NC; c++) ln_a[c] = 5'd3;
    run("pre_rst", 14);
    #3 rst_i = 1'b1;
    #1 chk("async_rst", 0, {9'd0, ch_en_o, ch_freq_o, busy_o, done_o, note_idx_o}, 32'd0);
    @(posedge clk);
    #1 chk("rst_hold", 0, {9'd0, ch_en_o, ch_freq_o, busy_o, done_o, note_idx_o}, 32'd0);
    #3 rst_i = 1'b0;
    model_reset();
    clear_stim();
    st_a[2] = 1;
    for (int c = 0; c < NC; c++) ln_a[c] = 5'd3;
    run("post_rst", 10);
    chk("post_rst:npulse", 0, act_t.size(), 1);
    if (act_t.size() > 0) begin
      chk("post_rst:pulse_cyc", 0, act_t[0], 4);
      chk("post_rst:pulse_freq", 0, act_f[0], 0);
    end
    chk("post_rst:ndone", 0, act_d.size(), 1);
    if (act_d.size() > 0) chk("post_rst:done_cyc", 0, act_d[0], 4);

    // Randomized traffic against the reference model
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      for (int c = 0; c < 150; c++) begin
        we_a[c] = ($urandom_range(0, 2) == 0);
        wa_a[c] = 4'($urandom_range(0, 15));
        wf_a[c] = 16'($urandom);
        wd_a[c] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        st_a[c] = ($urandom_range(0, 11) == 0);
        sp_a[c] = ($urandom_range(0, 49) == 0);
        ln_a[c] = 5'($urandom_range(0, 20));
        lp_a[c] = ($urandom_range(0, 1) == 1);
      end
      run($sformatf("rand%0d", r), 150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
